// File: rtl/program_counter_stack_pkg.sv
// Shared types, default widths and the counter-op priority encoder for program_counter_stack.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pc_pkg;

    localparam int PC_ADDR_W_DEF      = 4;
    localparam int PC_STACK_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        PC_OP_HOLD,
        PC_OP_INC,
        PC_OP_LOAD,
        PC_OP_JUMP,
        PC_OP_CALL,
        PC_OP_RET,
        PC_OP_COLLIDE
    } pc_op_e;

    // One counter op per edge.
    // Priority: load > WE > call&ret > call > ret > en > hold.
    // inc_block suppresses only the increment (breakpoint hold).
    function automatic pc_op_e pc_next_op(
        input logic load,
        input logic we,
        input logic call,
        input logic ret,
        input logic en,
        input logic inc_block
    );
        pc_op_e op;
        if (load)
            op = PC_OP_LOAD;
        else if (we)
            op = PC_OP_JUMP;
        else if (call && ret)
            op = PC_OP_COLLIDE;
        else if (call)
            op = PC_OP_CALL;
        else if (ret)
            op = PC_OP_RET;
        else if (en && !inc_block)
            op = PC_OP_INC;
        else
            op = PC_OP_HOLD;
        return op;
    endfunction

endpackage

// File: rtl/program_counter_stack_if.sv
// Control/status bundle between bus, sequencer, programmer and the program counter.
// Latency: n/a (wires only).
// Backpressure: none; every op is accepted on the edge where it is presented.
// Optional breakpoint signals are present only when PC_BREAKPOINT_EN is defined.
interface program_counter_stack_if
    import pc_pkg::*;
#(
    parameter int ADDR_W = PC_ADDR_W_DEF
);

    logic              en;
    logic              on;
    logic              load;
    logic              WE;
    logic              call;
    logic              ret;
    logic              OE;
    logic [ADDR_W-1:0] PC_in;
    logic [ADDR_W-1:0] PC_out;
    logic [ADDR_W-1:0] counter;
    logic              wrap;
    logic              stack_empty;
    logic              stack_full;
    logic              stack_err;
`ifdef PC_BREAKPOINT_EN
    logic              bp_set;
    logic              bp_clr;
    logic              bp_hit;
`endif

    // Driver side: bus, sequencer and programmer.
    modport master (
`ifdef PC_BREAKPOINT_EN
        output bp_set, bp_clr,
        input  bp_hit,
`endif
        output en, load, WE, call, ret, OE, PC_in,
        input  on, PC_out, counter, wrap, stack_empty, stack_full, stack_err
    );

    // Program counter side.
    modport slave (
`ifdef PC_BREAKPOINT_EN
        input  bp_set, bp_clr,
        output bp_hit,
`endif
        input  en, load, WE, call, ret, OE, PC_in,
        output on, PC_out, counter, wrap, stack_empty, stack_full, stack_err
    );

endinterface

// File: rtl/program_counter_stack_return_stack.sv
// Return-address LIFO: push/pop with full/empty flags and overflow/underflow strobes.
// Latency: push/pop take effect on the next CLK edge; top_dat/flags are combinational from the pointer.
// Backpressure: none; a push when full or a pop when empty is dropped and flagged by ovf/unf.
module pc_return_stack #(
    parameter int  DEPTH = 4,
    parameter int  W     = 4,
    localparam int PW    = $clog2(DEPTH + 1),
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  push_dat,
    output logic [W-1:0]  top_dat,
    output logic          full,
    output logic          empty,
    output logic [PW-1:0] sp,
    output logic          ovf,
    output logic          unf
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] top_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (sp == PW'(DEPTH));
    assign empty   = (sp == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty && !push;
    assign ovf     = push && full;
    assign unf     = pop && empty && !push;
    assign top_ptr = sp - PW'(1);
    assign top_dat = empty ? '0 : mem[top_ptr[IW-1:0]];

    // Stack pointer: up on accepted push, down on accepted pop.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            sp <= '0;
        else if (push_ok)
            sp <= sp + PW'(1);
        else if (pop_ok)
            sp <= sp - PW'(1);
    end

    // Entry storage: contents are don't-care after reset, so no reset here.
    always_ff @(posedge CLK) begin
        if (push_ok)
            mem[sp[IW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/program_counter_stack.sv
// Program counter with return-address stack, wrap pulse, sticky stack error and bus-side capture.
// Latency: counter/PC_out/wrap/stack_err update one CLK edge after the op; on and flags are combinational.
// Backpressure: none; illegal stack ops (overflow, underflow, call&ret) hold the counter and set stack_err.
// Optional breakpoint (bp_set/bp_clr/bp_hit) is built when PC_BREAKPOINT_EN is defined.
module program_counter_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W      = PC_ADDR_W_DEF,
    parameter int STACK_DEPTH = PC_STACK_DEPTH_DEF
) (
    input  logic                    CLK,
    input  logic                    RESET,
    program_counter_stack_if.slave  bus
);

    localparam int PW = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0] counter_q;
    logic [ADDR_W-1:0] pc_out_q;
    logic              wrap_q;
    logic              stack_err_q;
    logic              inc_block;
    pc_op_e            op;

    logic [ADDR_W-1:0] stk_top;
    logic              stk_full;
    logic              stk_empty;
    logic [PW-1:0]     stk_sp;
    logic              stk_ovf;
    logic              stk_unf;

`ifdef PC_BREAKPOINT_EN
    logic [ADDR_W-1:0] bp_addr;
    logic              bp_valid;
    logic              bp_hit;

    assign bp_hit     = bp_valid && (counter_q == bp_addr);
    assign bus.bp_hit = bp_hit;
    assign inc_block  = bp_hit;

    // Breakpoint register: clear beats set.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bp_addr  <= '0;
            bp_valid <= 1'b0;
        end else if (bus.bp_clr) begin
            bp_valid <= 1'b0;
        end else if (bus.bp_set) begin
            bp_addr  <= bus.PC_in;
            bp_valid <= 1'b1;
        end
    end
`else
    assign inc_block = 1'b0;
`endif

    assign op = pc_next_op(bus.load, bus.WE, bus.call, bus.ret, bus.en, inc_block);

    pc_return_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .CLK      (CLK),
        .RESET    (RESET),
        .push     (op == PC_OP_CALL),
        .pop      (op == PC_OP_RET),
        .push_dat (counter_q + ADDR_W'(1)),
        .top_dat  (stk_top),
        .full     (stk_full),
        .empty    (stk_empty),
        .sp       (stk_sp),
        .ovf      (stk_ovf),
        .unf      (stk_unf)
    );

    // Counter, wrap pulse and sticky stack error; exactly one op per edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            counter_q   <= '0;
            wrap_q      <= 1'b0;
            stack_err_q <= 1'b0;
        end else begin
            wrap_q      <= 1'b0;
            stack_err_q <= stack_err_q | stk_ovf | stk_unf | (op == PC_OP_COLLIDE);
            case (op)
                PC_OP_LOAD, PC_OP_JUMP: counter_q <= bus.PC_in;
                PC_OP_CALL: begin
                    if (!stk_full)
                        counter_q <= bus.PC_in;
                end
                PC_OP_RET: begin
                    if (!stk_empty)
                        counter_q <= stk_top;
                end
                PC_OP_INC: begin
                    counter_q <= counter_q + ADDR_W'(1);
                    wrap_q    <= &counter_q;
                end
                default: counter_q <= counter_q;
            endcase
        end
    end

    // Bus-side capture of the pre-edge counter, independent of the counter op.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            pc_out_q <= '0;
        else if (bus.OE)
            pc_out_q <= counter_q;
    end

    assign bus.on          = bus.en;
    assign bus.counter     = counter_q;
    assign bus.PC_out      = pc_out_q;
    assign bus.wrap        = wrap_q;
    assign bus.stack_err   = stack_err_q;
    assign bus.stack_empty = (stk_sp == '0);
    assign bus.stack_full  = (stk_sp == PW'(STACK_DEPTH));

endmodule

// File: tb/tb_program_counter_stack.sv
// Randomized and directed check of program_counter_stack against a queue-based reference model.
// Latency: model advances once per CLK edge; outputs sampled 1 time unit after the edge.
// Backpressure: n/a.
module tb_program_counter_stack;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2;
    localparam int MOD    = 1 << ADDR_W;

    logic CLK;
    logic RESET;

    program_counter_stack_if #(.ADDR_W(ADDR_W)) bus ();

    program_counter_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errs   = 0;

    // reference state
    int m_cnt;
    int m_pcout;
    bit m_wrap;
    bit m_err;
    int m_stk[$];
    int m_bpa;
    bit m_bpv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_pcout = 0; m_wrap = 0; m_err = 0;
        m_stk.delete();
        m_bpa = 0; m_bpv = 0;
    endtask

    task automatic model_edge();
        int old;
        bit hit;
        old = m_cnt;
        hit = 0;
`ifdef PC_BREAKPOINT_EN
        hit = m_bpv && (m_cnt == m_bpa);
`endif
        m_wrap = 0;
        if (bus.load || bus.WE)
            m_cnt = int'(bus.PC_in);
        else if (bus.call && bus.ret)
            m_err = 1;
        else if (bus.call) begin
            if (m_stk.size() >= DEPTH) m_err = 1;
            else begin
                m_stk.push_back((m_cnt + 1) % MOD);
                m_cnt = int'(bus.PC_in);
            end
        end else if (bus.ret) begin
            if (m_stk.size() == 0) m_err = 1;
            else m_cnt = m_stk.pop_back();
        end else if (bus.en && !hit) begin
            m_wrap = (m_cnt == MOD - 1);
            m_cnt  = (m_cnt + 1) % MOD;
        end
        if (bus.OE) m_pcout = old;
`ifdef PC_BREAKPOINT_EN
        if (bus.bp_clr) m_bpv = 0;
        else if (bus.bp_set) begin
            m_bpv = 1;
            m_bpa = int'(bus.PC_in);
        end
`endif
    endtask

    task automatic compare();
        chk("counter", 32'(bus.counter), 32'(m_cnt));
        chk("pc_out", 32'(bus.PC_out), 32'(m_pcout));
        chk("wrap", 32'(bus.wrap), 32'(m_wrap));
        chk("stack_err", 32'(bus.stack_err), 32'(m_err));
        chk("stack_empty", 32'(bus.stack_empty), 32'(m_stk.size() == 0));
        chk("stack_full", 32'(bus.stack_full), 32'(m_stk.size() == DEPTH));
`ifdef PC_BREAKPOINT_EN
        chk("bp_hit", 32'(bus.bp_hit), 32'(m_bpv && (m_cnt == m_bpa)));
`endif
    endtask

    task automatic step();
        chk("on", 32'(bus.on), 32'(bus.en));
        @(posedge CLK);
        #1;
        model_edge();
        compare();
    endtask

    task automatic drive(input bit ld, input bit we, input bit ca, input bit re,
                         input bit en, input bit oe, input int pin);
        bus.load  = ld;
        bus.WE    = we;
        bus.call  = ca;
        bus.ret   = re;
        bus.en    = en;
        bus.OE    = oe;
        bus.PC_in = ADDR_W'(pin);
        step();
    endtask

    initial begin
        RESET = 1'b1;
        bus.load = 0; bus.WE = 0; bus.call = 0; bus.ret = 0;
        bus.en = 0; bus.OE = 0; bus.PC_in = '0;
`ifdef PC_BREAKPOINT_EN
        bus.bp_set = 0; bus.bp_clr = 0;
`endif
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        compare();
        @(negedge CLK);
        RESET = 1'b0;

        // 17 increments from 0: wrap only on the F->0 edge
        for (int i = 0; i < 17; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0);
            chk("wrap_seq", 32'(bus.wrap), 32'(i == 15));
        end
        chk("cnt17", 32'(bus.counter), 32'h1);

        // nested call / return
        drive(1, 0, 0, 0, 0, 0, 3);
        drive(0, 0, 1, 0, 0, 0, 9);
        drive(0, 0, 1, 0, 0, 0, 12);
        chk("call2", 32'(bus.counter), 32'hC);
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("ret1", 32'(bus.counter), 32'hA);
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("ret2", 32'(bus.counter), 32'h4);
        chk("ret_empty", 32'(bus.stack_empty), 32'h1);

        // overflow then underflow
        drive(1, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 0, 0, 0, 5);
        drive(0, 0, 1, 0, 0, 0, 7);
        drive(0, 0, 1, 0, 0, 0, 9);
        chk("ovf_hold", 32'(bus.counter), 32'h7);
        chk("ovf_err", 32'(bus.stack_err), 32'h1);
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("unf_hold", 32'(bus.counter), 32'h2);

        // load beats call and en; call&ret collision holds
        drive(1, 0, 1, 0, 1, 0, 5);
        chk("load_pri", 32'(bus.counter), 32'h5);
        drive(0, 0, 1, 1, 0, 0, 11);
        chk("collide", 32'(bus.counter), 32'h5);

        // OE concurrent with increment
        drive(1, 0, 0, 0, 0, 0, 6);
        drive(0, 0, 0, 0, 1, 1, 0);
        chk("oe_pcout", 32'(bus.PC_out), 32'h6);
        chk("oe_cnt", 32'(bus.counter), 32'h7);

        // async reset mid-count, visible before the next edge
        RESET = 1'b1;
        #1;
        chk("rst_cnt", 32'(bus.counter), 32'h0);
        chk("rst_pcout", 32'(bus.PC_out), 32'h0);
        chk("rst_wrap", 32'(bus.wrap), 32'h0);
        chk("rst_err", 32'(bus.stack_err), 32'h0);
        model_reset();
        bus.en = 0;
        bus.OE = 0;
        @(negedge CLK);
        RESET = 1'b0;

`ifdef PC_BREAKPOINT_EN
        bus.bp_set = 1;
        drive(0, 0, 0, 0, 0, 0, 8);
        bus.bp_set = 0;
        drive(1, 0, 0, 0, 0, 0, 6);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1, 0, 0);
        chk("bp_stop", 32'(bus.counter), 32'h8);
        chk("bp_hit_on", 32'(bus.bp_hit), 32'h1);
        drive(0, 1, 0, 0, 1, 0, 2);
        chk("bp_jump", 32'(bus.counter), 32'h2);
        bus.bp_clr = 1;
        drive(0, 0, 0, 0, 0, 0, 0);
        bus.bp_clr = 0;
`endif

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
`ifdef PC_BREAKPOINT_EN
            bus.bp_set = ($urandom_range(0, 19) == 0);
            bus.bp_clr = ($urandom_range(0, 29) == 0);
`endif
            drive($urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, MOD - 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
